// File: rtl/frame_buffer_pkg.sv
// Shared types and constants for the frame buffer controller.
package frame_buffer_pkg;

  typedef enum logic {FILL, DRAIN} fb_state_t;

  // Words that may be buffered or in flight on the read side at once.
  localparam int unsigned CREDIT_LIMIT = 2;

  localparam int unsigned DATA_WIDTH = 32;

endpackage

// File: rtl/simple_dualport_mem.sv
// One write port, one registered read port (1-cycle latency); contents are never cleared.
module simple_dualport_mem #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DATA_AMOUNT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wea,
  input  logic [$clog2(DEPTH)-1:0] addra,
  input  int                       dina,
  input  logic                     enb,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  output int                       doutb,
  output logic                     read_ram_available
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_AMOUNT - 1);

  int ram [DEPTH];

  always_ff @(posedge clk) begin
    if (wea) ram[addra] <= dina;
    if (enb) doutb <= ram[addrb];
  end

  // High once the last frame location is written, until it is read back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_ram_available <= 1'b0;
    end else if (wea && addra == LAST_ADDR) begin
      read_ram_available <= 1'b1;
    end else if (enb && addrb == LAST_ADDR) begin
      read_ram_available <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Store-and-forward frame buffer: fills a RAM with one frame, then replays it in
// order through a 2-entry output buffer that hides the RAM read latency.
module frame_buffer_ctrl
  import frame_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DATA_AMOUNT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  int                     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output int                     out_data,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] fill_level
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] FRAME_LEN = CNT_WIDTH'(DATA_AMOUNT);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(DATA_AMOUNT - 1);

  if (DATA_AMOUNT < 2 || DATA_AMOUNT > DEPTH) begin : g_bad_amount
    $error("frame_buffer_ctrl: DATA_AMOUNT must lie in 2..DEPTH");
  end

  fb_state_t            state, next_state;
  logic [CNT_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic                 rd_inflight;
  logic                 skid_valid;
  int                   skid_data;

  logic                  in_hs;
  logic                  pop;
  logic                  issue;
  logic [1:0]            occupancy;
  logic                  mem_wea;
  logic [ADDR_WIDTH-1:0] mem_addra;
  logic [ADDR_WIDTH-1:0] mem_addrb;
  int                    ram_rdata;
  logic                  unused_ram_avail;

  // fill_level doubles as the write pointer: every frame starts at address 0.
  assign mem_addra = fill_level[ADDR_WIDTH-1:0];
  assign mem_addrb = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= next_state;
  end

  // Next state, handshakes and read-issue decision; flush overrides everything.
  always_comb begin
    next_state = state;
    in_hs      = in_valid && in_ready;
    pop        = out_valid && out_ready;
    frame_done = pop && (out_cnt == LAST_IDX) && !flush;
    occupancy  = 2'(out_valid) + 2'(skid_valid) + 2'(rd_inflight);
    issue      = 1'b0;
    mem_wea    = 1'b0;
    case (state)
      FILL: begin
        mem_wea = in_hs;
        if (in_hs && fill_level == LAST_IDX) next_state = DRAIN;
      end
      DRAIN: begin
        issue = (rd_ptr < FRAME_LEN) && ((occupancy - 2'(pop)) < 2'(CREDIT_LIMIT));
        if (frame_done) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
    if (flush) begin
      next_state = FILL;
      mem_wea    = 1'b0;
      issue      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready <= 1'b0;
    else        in_ready <= (next_state == FILL);
  end

  // Pointers plus holding/skid buffer; returning read data fills the holding slot first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_level  <= '0;
      rd_ptr      <= '0;
      out_cnt     <= '0;
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 0;
      skid_valid  <= 1'b0;
      skid_data   <= 0;
    end else if (flush) begin
      fill_level  <= '0;
      rd_ptr      <= '0;
      out_cnt     <= '0;
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      if (mem_wea) fill_level <= fill_level + CNT_WIDTH'(1);
      if (issue)   rd_ptr     <= rd_ptr + CNT_WIDTH'(1);
      if (pop)     out_cnt    <= out_cnt + CNT_WIDTH'(1);
      if (frame_done) begin
        fill_level <= '0;
        rd_ptr     <= '0;
        out_cnt    <= '0;
      end
      rd_inflight <= issue;
      if (pop && skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (rd_inflight && (!out_valid || pop)) begin
        out_valid <= 1'b1;
        out_data  <= ram_rdata;
      end else if (rd_inflight) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_rdata;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

  simple_dualport_mem #(
    .DEPTH       (DEPTH),
    .DATA_AMOUNT (DATA_AMOUNT)
  ) u_mem (
    .clk                (clk),
    .rst_n              (rst_n),
    .wea                (mem_wea),
    .addra              (mem_addra),
    .dina               (in_data),
    .enb                (issue),
    .addrb              (mem_addrb),
    .doutb              (ram_rdata),
    .read_ram_available (unused_ram_avail)
  );

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: three parameterisations checked every cycle against
// a frame-level model, plus directed scenarios with hand-computed timing.
module tb_frame_buffer_ctrl;
  import frame_buffer_pkg::*;

  localparam int NI = 3;
  localparam int N_T [NI] = '{16, 2, 5};
  localparam int D_T [NI] = '{16, 2, 8};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] flush;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] frame_done;
  logic [NI-1:0] addr_ok;
  logic [NI-1:0] in_fill;
  int            in_data    [NI];
  int            out_data   [NI];
  int            rd_ptr_obs [NI];
  logic [4:0]    fill_level [NI];

  int checks = 0;
  int errors = 0;

  // Model state: words accepted this frame, drain progress, edges since frame complete.
  int frame_mem [NI][16];
  int cnt_m [NI];
  int oidx_m [NI];
  int age_m [NI];
  int since_rst [NI];
  int frames_seen [NI];
  bit full_m [NI];
  bit prev_stall [NI];
  int prev_data [NI];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    logic [$clog2(D_T[i]):0] fl;
    frame_buffer_ctrl #(
      .DEPTH       (D_T[i]),
      .DATA_AMOUNT (N_T[i])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush[i]),
      .in_valid   (in_valid[i]),
      .in_ready   (in_ready[i]),
      .in_data    (in_data[i]),
      .out_valid  (out_valid[i]),
      .out_ready  (out_ready[i]),
      .out_data   (out_data[i]),
      .frame_done (frame_done[i]),
      .fill_level (fl)
    );
    assign fill_level[i] = 5'(fl);
    assign rd_ptr_obs[i] = 32'(u_dut.rd_ptr);
    assign in_fill[i]    = (u_dut.state == FILL);
    assign addr_ok[i]    = !(u_dut.mem_wea && 32'(u_dut.mem_addra) >= 32'(N_T[i])) &&
                           !(u_dut.issue   && 32'(u_dut.mem_addrb) >= 32'(N_T[i]));
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the frame model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        full_m[k] = 1'b0; cnt_m[k] = 0; oidx_m[k] = 0; age_m[k] = 0;
        since_rst[k] = 0; prev_stall[k] = 1'b0;
      end else begin
        bit exp_valid, exp_ready, in_hs, pop;
        int n;
        n = N_T[k];
        exp_valid = full_m[k] && age_m[k] >= 2;
        exp_ready = since_rst[k] >= 1 && !full_m[k];
        pop       = exp_valid && out_ready[k];
        chk("out_valid", longint'(out_valid[k]), longint'(exp_valid));
        if (exp_valid) chk("out_data", out_data[k], frame_mem[k][oidx_m[k]]);
        chk("in_ready", longint'(in_ready[k]), longint'(exp_ready));
        chk("fill_level", longint'(fill_level[k]), cnt_m[k]);
        chk("frame_done", longint'(frame_done[k]),
            longint'(pop && oidx_m[k] == n - 1 && !flush[k]));
        chk("addr_range", longint'(addr_ok[k]), 1);
        if (prev_stall[k]) chk("stall_hold", out_data[k], prev_data[k]);
        prev_stall[k] = exp_valid && !out_ready[k] && !flush[k];
        prev_data[k]  = out_data[k];
        in_hs = in_valid[k] && exp_ready;
        if (flush[k]) begin
          full_m[k] = 1'b0; cnt_m[k] = 0; oidx_m[k] = 0; age_m[k] = 0;
        end else begin
          if (full_m[k]) age_m[k]++;
          if (in_hs) begin
            frame_mem[k][cnt_m[k]] = in_data[k];
            cnt_m[k]++;
            if (cnt_m[k] == n) begin full_m[k] = 1'b1; age_m[k] = 0; end
          end
          if (pop) begin
            if (oidx_m[k] == n - 1) begin
              frames_seen[k]++;
              full_m[k] = 1'b0; cnt_m[k] = 0; oidx_m[k] = 0;
            end else begin
              oidx_m[k]++;
            end
          end
        end
        if (since_rst[k] < 10) since_rst[k]++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_frame(input int k, input int n, input int base);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < n && guard < 100) begin
      in_valid[k] = 1'b1;
      in_data[k]  = base + i;
      hs = in_ready[k];
      step();
      if (hs) i++;
      guard++;
    end
    in_valid[k] = 1'b0;
    chk("write_frame_words", i, n);
  endtask

  task automatic wait_frame(input int k);
    int target = frames_seen[k] + 1;
    int c = 0;
    while (frames_seen[k] < target && c < 100) begin step(); c++; end
    chk("wait_frame_done", frames_seen[k], target);
  endtask

  task automatic run_random(input int k, input int nframes, input int budget);
    int target = frames_seen[k] + nframes;
    int c = 0;
    while (frames_seen[k] < target && c < budget) begin
      in_valid[k]  = ($urandom_range(0, 9) < 7);
      in_data[k]   = int'($urandom);
      out_ready[k] = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    chk("random_frames", frames_seen[k], target);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0; flush = '0; in_valid = '0; out_ready = '0;
    for (int k = 0; k < NI; k++) begin
      in_data[k] = 0; frames_seen[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready[0]), 0);
    chk("reset_out_valid", longint'(out_valid[0]), 0);
    chk("reset_fill_level", longint'(fill_level[0]), 0);
    rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", longint'(in_ready[0]), 1);

    // Single frame, no backpressure: words 0..15 accepted on edges 0..15.
    out_ready[0] = 1'b1;
    write_frame(0, 16, 0);
    t = 15;
    while (!out_valid[0] && t < 40) begin step(); t++; end
    chk("first_valid_edge", t, 17);
    chk("first_word", out_data[0], 0);
    while (!frame_done[0] && t < 60) begin step(); t++; end
    chk("frame_done_edge", t, 32);
    chk("last_word", out_data[0], 15);
    step();
    chk("recover_in_ready", longint'(in_ready[0]), 1);
    chk("recover_out_valid", longint'(out_valid[0]), 0);

    // Random gaps and backpressure over 20 frames.
    run_random(0, 20, 8000);

    // Sustained stall at drain start: only two reads may be outstanding.
    out_ready[0] = 1'b0;
    write_frame(0, 16, 100);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_rd_ptr", rd_ptr_obs[0], 2);
    chk("stall_out_valid", longint'(out_valid[0]), 1);
    chk("stall_out_data", out_data[0], 100);
    out_ready[0] = 1'b1;
    t = 0;
    while (!frame_done[0] && t < 40) begin step(); t++; end
    chk("release_cycles", t, 15);
    chk("release_last_word", out_data[0], 115);
    step();

    // Flush mid-FILL, racing a handshake.
    write_frame(0, 7, 200);
    flush[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 999;
    step();
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    chk("flush_fill_level", longint'(fill_level[0]), 0);
    chk("flush_out_valid", longint'(out_valid[0]), 0);
    chk("flush_in_ready", longint'(in_ready[0]), 1);
    write_frame(0, 16, 300);
    wait_frame(0);

    // Flush mid-DRAIN with a read in flight.
    out_ready[0] = 1'b0;
    write_frame(0, 16, 400);
    step();
    chk("drain_rd_ptr", rd_ptr_obs[0], 1);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    chk("dflush_fill_level", longint'(fill_level[0]), 0);
    chk("dflush_out_valid", longint'(out_valid[0]), 0);
    chk("dflush_rd_ptr", rd_ptr_obs[0], 0);
    chk("dflush_state_fill", longint'(in_fill[0]), 1);
    step();
    chk("dflush_discard", longint'(out_valid[0]), 0);
    out_ready[0] = 1'b1;
    write_frame(0, 16, 500);
    wait_frame(0);

    // Asynchronous reset between edges mid-DRAIN.
    out_ready[0] = 1'b0;
    write_frame(0, 16, 600);
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", longint'(out_valid[0]), 0);
    chk("areset_fill_level", longint'(fill_level[0]), 0);
    chk("areset_in_ready", longint'(in_ready[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("areset_state_fill", longint'(in_fill[0]), 1);
    chk("areset_in_ready_after", longint'(in_ready[0]), 1);
    out_ready[0] = 1'b1;
    write_frame(0, 16, 700);
    wait_frame(0);
    chk("frames_inst0", frames_seen[0], 25);

    // Parameter corners: (DEPTH 2, AMOUNT 2) and (DEPTH 8, AMOUNT 5).
    out_ready[1] = 1'b1;
    write_frame(1, 2, 10);
    wait_frame(1);
    run_random(1, 6, 2000);
    chk("frames_inst1", frames_seen[1], 7);
    out_ready[2] = 1'b1;
    write_frame(2, 5, 20);
    wait_frame(2);
    run_random(2, 6, 2000);
    chk("frames_inst2", frames_seen[2], 7);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Store-and-forward controller around a `simple_dualport_mem` instance. It accepts a frame of exactly DATA_AMOUNT `int` words on a valid/ready input stream and writes them to the RAM. It then replays the frame in order on a valid/ready output stream, hiding the RAM's 1-cycle read latency and honouring output backpressure. It sits between a producer stage and a consumer stage that must see whole frames only.

## Interface
- DEPTH, 16, RAM locations; ADDR_WIDTH = $clog2(DEPTH) is a localparam.
- DATA_AMOUNT, 16, words per frame; legal range 2..DEPTH, elaboration error otherwise.
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous abort of the current frame.
- in_valid  in  1  producer word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  32 (`int`)  producer word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  32 (`int`)  replayed word.
- frame_done  out  1  one-cycle pulse on the last output handshake of a frame.
- fill_level  out  ADDR_WIDTH+1  words written in the current frame, 0..DATA_AMOUNT.

## Operation
- States: FILL, DRAIN.
- Reset state: FILL. Reset values: wr_ptr=0, rd_ptr=0, fill_level=0, out_valid=0, frame_done=0, in_ready=0 during reset. RAM contents are not cleared.
- FILL:
  - in_ready=1.
  - On handshake, wea=1, addra=wr_ptr, dina=in_data; wr_ptr and fill_level increment.
  - The handshake that makes fill_level reach DATA_AMOUNT moves the state to DRAIN. In DRAIN, in_ready=0.
- DRAIN:
  - Read issue: addrb=rd_ptr and rd_ptr increments when rd_ptr<DATA_AMOUNT and credits allow.
  - Credits = output holding register + 1-entry skid register + in-flight read; maximum 2 words outstanding.
  - A read issues when (occupied + in-flight − pop this cycle) < 2.
  - Returned RAM data lands in the holding register if that register is empty or is being popped; otherwise it goes to the skid register.
  - Words leave strictly in address order 0..DATA_AMOUNT−1. There are no duplicates or drops under any out_ready pattern.
  - On the output handshake of word DATA_AMOUNT−1:
    - frame_done=1 for that one cycle.
    - wr_ptr, rd_ptr and fill_level return to 0.
    - Next state is FILL; in_ready=1 from the next cycle.
- flush (either state): next cycle is FILL with pointers, fill_level, out_valid and both buffers cleared. Any in-flight read data is discarded. frame_done is not pulsed. flush takes priority over a same-cycle handshake.
- Pointers never wrap within a frame. Every frame starts at address 0.
- Write and read never target the RAM in the same cycle, so there is no collision case.

## Timing
- Write latency: in_data is captured in the RAM at the handshake edge.
- Drain start: the first read issues in the first DRAIN cycle. out_valid rises 2 cycles after the final input handshake edge.
- Throughput: with out_ready held high, one word per cycle. A frame's output occupies DATA_AMOUNT consecutive cycles.
- Backpressure: out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- Recovery: the first word of a new frame can be accepted the cycle after frame_done.
- Asynchronous reset mid-frame: outputs take reset values immediately. The partial frame is lost.

## Structure
- Package `frame_buffer_pkg` holds:
  - `typedef enum logic {FILL, DRAIN} fb_state_t`.
  - A credit limit constant (=2).
- The sub-module is `simple_dualport_mem` with DEPTH and DATA_AMOUNT passed through.
  - Its read_ram_available output is unused; this controller uses its own fill_level.
- Controller FSM, pointers and the 2-entry output buffer live in one file.

## Test plan
- Single frame, no backpressure: DATA_AMOUNT=16, write 0..15 back-to-back, out_ready=1 → 16 consecutive outputs 0..15; frame_done on word 15; in_ready=1 the next cycle.
- Random out_ready (50%) and random in_valid gaps over 20 frames of random data → scoreboard exact order; out_data stable while stalled; no loss.
- Sustained stall: hold out_ready=0 for 10 cycles at drain start → exactly 2 RAM reads issued (rd_ptr=2); out_data=word 0 held; release → rest streams 1/cycle.
- Flush mid-FILL after 7 words, and mid-DRAIN with a read in flight → next cycle FILL, fill_level=0, out_valid=0, no frame_done; next frame replays only new data.
- Async reset asserted mid-DRAIN between clock edges → out_valid=0 and fill_level=0 immediately; after release, state FILL, in_ready=1.
- Parameter corner: DATA_AMOUNT=2, DEPTH=2; and DATA_AMOUNT=5, DEPTH=8 → correct replay and frame_done, with addresses confined to 0..DATA_AMOUNT−1.
